// File: rtl/wb_queue.sv
// Writeback queue: merges ALU (A) and load (B) results into one in-order
// FIFO and drains one entry per cycle onto the register-file write port.
//
// Ports:
//   CLK, RESET                   clock, async active-low reset
//   A_Valid/A_Reg/A_Data/A_Ready ALU writeback handshake
//   B_Valid/B_Reg/B_Data/B_Ready load writeback handshake
//   WriteReg1/WriteData1/Write1  registered register-file write port
//   QueryReg/QueryPending        pending-write lookup for decode stalls
//   Count                        FIFO occupancy (output register excluded)
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          A_Valid,
  input  logic [4:0]    A_Reg,
  input  logic [31:0]   A_Data,
  output logic          A_Ready,
  input  logic          B_Valid,
  input  logic [4:0]    B_Reg,
  input  logic [31:0]   B_Data,
  output logic          B_Ready,
  output logic [4:0]    WriteReg1,
  output logic [31:0]   WriteData1,
  output logic          Write1,
  input  logic [4:0]    QueryReg,
  output logic          QueryPending,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL_M2 = (AW+1)'(DEPTH - 2);

  logic [4:0]       reg_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] wr_b;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic          w1_q;
  logic [4:0]    wreg_q;
  logic [31:0]   wdat_q;

  logic push_a;
  logic push_b;
  logic pop;
  logic hit;

  // Readiness looks only at registered occupancy; a same-cycle
  // pop earns no credit. B yields the last free slot to A.
  assign A_Ready = (count_q <= FULL_M1);
  assign B_Ready = (count_q <= FULL_M2) ||
                   ((count_q == FULL_M1) && !A_Valid);

  // Register 0 writes finish the handshake but are dropped.
  assign push_a = A_Valid && A_Ready && (A_Reg != 5'd0);
  assign push_b = B_Valid && B_Ready && (B_Reg != 5'd0);
  assign pop    = (count_q != '0);

  // A takes the older slot when both arrive together.
  assign wr_b = push_a ? wr_q + AW'(1) : wr_q;

  assign count_d = count_q
                 + (AW+1)'(push_a)
                 + (AW+1)'(push_b)
                 - (AW+1)'(pop);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      vld_q   <= '0;
      w1_q    <= 1'b0;
      wreg_q  <= '0;
      wdat_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wr_q    <= wr_q + AW'(push_a) + AW'(push_b);
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + AW'(1);
        w1_q        <= 1'b1;
        wreg_q      <= reg_q[rd_q];
        wdat_q      <= dat_q[rd_q];
      end else begin
        w1_q <= 1'b0;
      end
      // Push slots never alias the head being popped.
      if (push_a) begin
        reg_q[wr_q] <= A_Reg;
        dat_q[wr_q] <= A_Data;
        vld_q[wr_q] <= 1'b1;
      end
      if (push_b) begin
        reg_q[wr_b] <= B_Reg;
        dat_q[wr_b] <= B_Data;
        vld_q[wr_b] <= 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (reg_q[i] == QueryReg)) hit = 1'b1;
    end
    if (w1_q && (wreg_q == QueryReg)) hit = 1'b1;
  end

  assign QueryPending = hit && (QueryReg != 5'd0);

  assign Write1     = w1_q;
  assign WriteReg1  = wreg_q;
  assign WriteData1 = wdat_q;
  assign Count      = count_q;

endmodule
